fpm_share_ctrl: RTL and testbench
=================================

Name: fpm_share_ctrl

Overview:
Controller that time-shares one combinational single-precision floating-point multiplier (FPM: sign XOR, exponent add with bias removal, 24x24 mantissa multiply, normalize) between NUM_REQ requesters. It arbitrates round-robin and registers the winning operands onto the FPM inputs. It holds them for a fixed multicycle window (MUL_LAT), because the FPM mantissa tree is a multicycle path. It then captures product and flags into a response register with valid/ready handshake. The block sits between requester-side engines and the single FPM instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ID_W, 2, width of resp_id; must satisfy NUM_REQ <= 2**ID_W
MUL_LAT, 3, cycles operands are held stable on fpm_a/fpm_b before capture (>=1)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  per-requester accept; at most one bit high
req_a  in  32*NUM_REQ  operand A per requester; slice i = bits [32i+31:32i]
req_b  in  32*NUM_REQ  operand B per requester, same packing
fpm_a  out  32  operand A to FPM
fpm_b  out  32  operand B to FPM
fpm_m  in  32  FPM product
fpm_underflow  in  1  FPM underflow flag
fpm_overflow  in  1  FPM overflow flag
resp_valid  out  1  response valid
resp_ready  in  1  response consumer ready
resp_id  out  ID_W  index of requester that owns the response
resp_m  out  32  captured product
resp_underflow  out  1  captured underflow
resp_overflow  out  1  captured overflow
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst=1): state=IDLE; the round-robin pointer last_grant is set to NUM_REQ-1, so requester 0 has first priority. Op registers, fpm_a, fpm_b, resp_m, resp_id, all flags, resp_valid and busy are all 0. Wait counter is 0.
- States: IDLE, WAIT, DONE.
- IDLE: the winner is the first i with req_valid[i]=1, searched from last_grant+1 upward and wrapping modulo NUM_REQ. req_ready is combinational and one-hot to the winner, only in IDLE; all zero otherwise. Handshake happens on a clock edge with req_valid[i] & req_ready[i]. On that edge the block latches req_a/req_b slice i into the op registers (driving fpm_a/fpm_b) and stores i as the owner. It sets last_grant=i, loads cnt=MUL_LAT-1, and goes to WAIT. With no valid request it stays in IDLE.
- WAIT: fpm_a/fpm_b stay stable. If cnt!=0, cnt decrements. If cnt==0, on that edge the block captures fpm_m, fpm_underflow and fpm_overflow into the resp registers, sets resp_id to the owner and resp_valid=1, and goes to DONE.
- DONE: the response is held stable. On an edge with resp_ready=1 the block clears resp_valid and goes to IDLE. A new grant cannot happen before the following IDLE cycle.
- Latency: the accepting edge is E0. resp_valid rises at edge E0+MUL_LAT. Minimum request-to-request spacing is MUL_LAT+2 cycles with resp_ready held at 1.
- Requesters must hold req_valid and operands stable until accepted. Changes to non-granted inputs never affect the operation in flight.
- A requester that drops req_valid before grant is simply skipped. Simultaneous requests are resolved by the pointer only.
- resp_ready asserted outside DONE is ignored.
- Reset mid-operation: the in-flight operation is discarded with no response. After release, arbitration restarts from requester 0.
- fpm_a/fpm_b keep their last operands in IDLE and DONE; they are not cleared.

Optional Feature:
FPM_ZERO_BYPASS_EN: defined -> at grant, if either operand has exponent field [30:23]==0, the block skips WAIT and goes directly to DONE on the same edge. It loads resp_m={a[31]^b[31],31'b0} and resp_underflow=resp_overflow=0, so resp_valid rises at E0. The pointer updates as normal. fpm_a/fpm_b are still loaded. Undefined -> zero/denormal operands go through the normal WAIT path and FPM output is returned unchanged.

Test Plan:
- Single op: after reset, req_valid[0]=1, a=0x3FC00000 (1.5), b=0x40000000 (2.0), MUL_LAT=3 -> req_ready[0] high in that cycle; resp_valid 3 cycles after accept; resp_m=0x40400000, resp_id=0, flags 0.
- Sign: req 2, a=0xBFC00000, b=0x40000000 -> resp_m=0xC0400000, resp_id=2.
- Round robin: all four req_valid held high, resp_ready=1 -> grant order 0,1,2,3,0; resp_id sequence matches; grants spaced 5 cycles apart; req_ready never multi-hot.
- Backpressure: resp_ready=0 for 6 cycles in DONE with req_valid[1]=1 -> resp_* stable, req_ready all 0, busy=1; on resp_ready=1, IDLE next cycle, then grant to 1.
- Reset mid-WAIT: rst pulsed one cycle after a grant to req 3 -> resp_valid stays 0, all outputs 0; with req 0 and req 3 valid afterwards, req 0 is granted first.
- Bypass (FPM_ZERO_BYPASS_EN defined): a=0x80000000, b=0x40000000 -> resp_valid at E0, resp_m=0x80000000, flags 0. Without the macro -> resp_valid at E0+3 and resp_m equals fpm_m.

Source files
------------

// File: rtl/fpm_share_if.sv
// Requester/FPM/response bundle for fpm_share_ctrl. The controller takes the
// slave view. The requester/FPM/consumer side takes the master view.
interface fpm_share_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic [31:0]           fpm_a;
  logic [31:0]           fpm_b;
  logic [31:0]           fpm_m;
  logic                  fpm_underflow;
  logic                  fpm_overflow;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [ID_W-1:0]       resp_id;
  logic [31:0]           resp_m;
  logic                  resp_underflow;
  logic                  resp_overflow;
  logic                  busy;

  modport slave (
    input  req_valid, req_a, req_b, fpm_m, fpm_underflow, fpm_overflow, resp_ready,
    output req_ready, fpm_a, fpm_b, resp_valid, resp_id, resp_m,
           resp_underflow, resp_overflow, busy
  );

  modport master (
    output req_valid, req_a, req_b, fpm_m, fpm_underflow, fpm_overflow, resp_ready,
    input  req_ready, fpm_a, fpm_b, resp_valid, resp_id, resp_m,
           resp_underflow, resp_overflow, busy
  );
endinterface

// File: rtl/fpm_share_ctrl.sv
// Round-robin time-sharing controller for one combinational FP multiplier.
// Optional macro FPM_ZERO_BYPASS_EN answers zero/denormal operands at grant.
module fpm_share_ctrl #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int MUL_LAT = 3
) (
  input  logic         clk,
  input  logic         rst,
  fpm_share_if.slave   bus
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [ID_W-1:0] r_last_grant;
  logic [ID_W-1:0] r_owner;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]     r_op_a;
  logic [31:0]     r_op_b;
  logic [31:0]     r_resp_m;
  logic [ID_W-1:0] r_resp_id;
  logic            r_resp_uf;
  logic            r_resp_of;
  logic            r_resp_valid;
  logic            r_busy;

  logic               w_grant_any;
  logic [ID_W-1:0]    w_grant_idx;
  logic [NUM_REQ-1:0] w_req_ready;
  logic [31:0]        w_sel_a;
  logic [31:0]        w_sel_b;

  // Walk from the farthest candidate back to last_grant+1 so the nearest
  // valid requester is the final (winning) assignment.
  always_comb begin
    int idx;
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and infers a latch.
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    idx         = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(r_last_grant) + k) % NUM_REQ;
      if (bus.req_valid[idx[IDX_W-1:0]]) begin
        w_grant_any = 1'b1;
        w_grant_idx = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_sel_a     = '0;
    w_sel_b     = '0;
    w_req_ready = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant_idx == ID_W'(i)) begin
        w_sel_a        = bus.req_a[32*i +: 32];
        w_sel_b        = bus.req_b[32*i +: 32];
        w_req_ready[i] = w_grant_any && (r_state == S_IDLE);
      end
    end
  end

`ifdef FPM_ZERO_BYPASS_EN
  logic w_zero_op;
  assign w_zero_op = (w_sel_a[30:23] == 8'd0) || (w_sel_b[30:23] == 8'd0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_last_grant <= ID_W'(NUM_REQ - 1);
      r_owner      <= '0;
      r_cnt        <= '0;
      r_op_a       <= '0;
      r_op_b       <= '0;
      r_resp_m     <= '0;
      r_resp_id    <= '0;
      r_resp_uf    <= 1'b0;
      r_resp_of    <= 1'b0;
      r_resp_valid <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      case (r_state)
        S_IDLE: begin
          if (w_grant_any) begin
            r_op_a       <= w_sel_a;
            r_op_b       <= w_sel_b;
            r_owner      <= w_grant_idx;
            r_last_grant <= w_grant_idx;
            r_cnt        <= CNT_W'(MUL_LAT - 1);
            r_busy       <= 1'b1;
`ifdef FPM_ZERO_BYPASS_EN
            if (w_zero_op) begin
              r_resp_m     <= {w_sel_a[31] ^ w_sel_b[31], 31'b0};
              r_resp_uf    <= 1'b0;
              r_resp_of    <= 1'b0;
              r_resp_id    <= w_grant_idx;
              r_resp_valid <= 1'b1;
              r_state      <= S_DONE;
            end else begin
              r_state      <= S_WAIT;
            end
`else
            r_state      <= S_WAIT;
`endif
          end
        end
        S_WAIT: begin
          // Operands stay frozen on fpm_a/fpm_b for the whole multicycle window.
          if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end else begin
            r_resp_m     <= bus.fpm_m;
            r_resp_uf    <= bus.fpm_underflow;
            r_resp_of    <= bus.fpm_overflow;
            r_resp_id    <= r_owner;
            r_resp_valid <= 1'b1;
            r_state      <= S_DONE;
          end
        end
        S_DONE: begin
          if (bus.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready      = w_req_ready;
  assign bus.fpm_a          = r_op_a;
  assign bus.fpm_b          = r_op_b;
  assign bus.resp_valid     = r_resp_valid;
  assign bus.resp_id        = r_resp_id;
  assign bus.resp_m         = r_resp_m;
  assign bus.resp_underflow = r_resp_uf;
  assign bus.resp_overflow  = r_resp_of;
  assign bus.busy           = r_busy;

endmodule

// File: tb/tb_fpm_share_ctrl.sv
// Randomized self-checking bench for fpm_share_ctrl with a transaction-level
// model (countdown per operation) and a behavioural FP multiplier stand-in.
module tb_fpm_share_ctrl;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int MUL_LAT = 3;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  fpm_share_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus ();

  fpm_share_ctrl #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .MUL_LAT(MUL_LAT)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-precision multiply (truncating), returns {uf, of, m}.
  function automatic logic [33:0] fpm_ref(input logic [31:0] a, input logic [31:0] b);
    logic        s;
    int          e;
    logic [47:0] p;
    logic [22:0] f;
    s = a[31] ^ b[31];
    if (a[30:23] == 8'd0 || b[30:23] == 8'd0) return {2'b00, s, 31'b0};
    p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
    e = int'(a[30:23]) + int'(b[30:23]) - 127;
    if (p[47]) begin
      f = p[46:24];
      e = e + 1;
    end else begin
      f = p[45:23];
    end
    if (e >= 255) return {2'b01, s, 8'hFF, 23'b0};
    if (e <= 0)   return {2'b10, s, 31'b0};
    return {2'b00, s, e[7:0], f};
  endfunction

  always_comb {bus.fpm_underflow, bus.fpm_overflow, bus.fpm_m} = fpm_ref(bus.fpm_a, bus.fpm_b);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Transaction-level model state.
  bit          m_idle;
  bit          m_rvalid;
  int          m_left;
  int          m_ptr;
  int          m_owner;
  int          m_last_win;
  logic [31:0] m_a, m_b;
  logic [33:0] m_resp;
  int          m_rid;
  int          cyc;
  int          grant_idx_q[$];
  int          grant_cyc_q[$];

  function automatic logic [31:0] slice_of(input logic [32*NUM_REQ-1:0] v, input int i);
    return v[32*i +: 32];
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_rvalid = 1'b0; m_left = 0; m_ptr = NUM_REQ - 1;
    m_owner = 0; m_a = '0; m_b = '0; m_resp = '0; m_rid = 0; m_last_win = -1;
  endtask

  // Called at a negedge with inputs already applied; checks, advances the
  // model across the coming posedge, and returns at the next negedge.
  task automatic tick();
    logic [NUM_REQ-1:0] exp_ready;
    int win;
    #1;
    win = -1;
    if (m_idle) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        int i;
        i = (m_ptr + k) % NUM_REQ;
        if (win < 0 && bus.req_valid[i]) win = i;
      end
    end
    exp_ready = '0;
    if (win >= 0) exp_ready[win] = 1'b1;
    check("req_ready", 64'(bus.req_ready), 64'(exp_ready));
    check("req_ready_onehot0", 64'($onehot0(bus.req_ready)), 64'(1));
    check("busy", 64'(bus.busy), 64'(!m_idle));
    check("fpm_a", 64'(bus.fpm_a), 64'(m_a));
    check("fpm_b", 64'(bus.fpm_b), 64'(m_b));
    check("resp_valid", 64'(bus.resp_valid), 64'(m_rvalid));
    if (m_rvalid) begin
      check("resp_id", 64'(bus.resp_id), 64'(m_rid));
      check("resp_m", 64'(bus.resp_m), 64'(m_resp[31:0]));
      check("resp_flags", 64'({bus.resp_underflow, bus.resp_overflow}), 64'(m_resp[33:32]));
    end
    if (bus.req_ready != '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.req_ready[i]) begin
          grant_idx_q.push_back(i);
          grant_cyc_q.push_back(cyc);
        end
      end
    end
    m_last_win = win;
    if (m_idle) begin
      if (win >= 0) begin
        m_ptr = win; m_owner = win;
        m_a = slice_of(bus.req_a, win);
        m_b = slice_of(bus.req_b, win);
        m_idle = 1'b0;
        m_left = MUL_LAT;
`ifdef FPM_ZERO_BYPASS_EN
        if (m_a[30:23] == 8'd0 || m_b[30:23] == 8'd0) begin
          m_resp = {2'b00, m_a[31] ^ m_b[31], 31'b0};
          m_rid = win; m_rvalid = 1'b1;
        end
`endif
      end
    end else if (!m_rvalid) begin
      m_left--;
      if (m_left == 0) begin
        m_resp = fpm_ref(m_a, m_b);
        m_rid = m_owner; m_rvalid = 1'b1;
      end
    end else if (bus.resp_ready) begin
      m_rvalid = 1'b0; m_idle = 1'b1;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    rst = 1'b1;
    model_reset();
    #1;
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_resp_valid", 64'(bus.resp_valid), 64'(0));
    check("rst_resp_m", 64'(bus.resp_m), 64'(0));
    check("rst_resp_id", 64'(bus.resp_id), 64'(0));
    check("rst_flags", 64'({bus.resp_underflow, bus.resp_overflow}), 64'(0));
    check("rst_fpm_a", 64'(bus.fpm_a), 64'(0));
    check("rst_fpm_b", 64'(bus.fpm_b), 64'(0));
    check("rst_req_ready", 64'(bus.req_ready), 64'(0));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  function automatic logic [31:0] rnd_fp();
    logic [7:0] e;
    case ($urandom_range(0, 7))
      0:       e = 8'd0;
      1:       e = 8'($urandom_range(230, 254));
      2:       e = 8'($urandom_range(1, 20));
      default: e = 8'($urandom_range(100, 154));
    endcase
    return {1'($urandom_range(0, 1)), e, 23'($urandom)};
  endfunction

  initial begin
    n_vec = 0; n_err = 0; cyc = 0;
    rst = 1'b1;
    bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.resp_ready = 1'b0;
    model_reset();
    @(negedge clk);

    // Single op on requester 0, then backpressure with requester 1 waiting.
    do_reset();
    bus.resp_ready = 1'b0;
    set_req(0, 32'h3FC0_0000, 32'h4000_0000);
    tick();
    bus.req_valid = '0;
    repeat (MUL_LAT) tick();
    #1;
    check("single_resp_m", 64'(bus.resp_m), 64'h4040_0000);
    check("single_resp_id", 64'(bus.resp_id), 64'(0));
    set_req(1, 32'h4040_0000, 32'h4000_0000);
    repeat (6) tick();
    bus.resp_ready = 1'b1;
    tick();
    bus.resp_ready = 1'b0;
    #1;
    check("bp_grant_1", 64'(bus.req_ready), 64'h2);
    tick();
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    repeat (MUL_LAT + 2) tick();

    // Sign handling on requester 2.
    do_reset();
    bus.resp_ready = 1'b0;
    set_req(2, 32'hBFC0_0000, 32'h4000_0000);
    tick();
    bus.req_valid = '0;
    repeat (MUL_LAT) tick();
    #1;
    check("sign_resp_m", 64'(bus.resp_m), 64'hC040_0000);
    check("sign_resp_id", 64'(bus.resp_id), 64'(2));
    bus.resp_ready = 1'b1;
    tick();

    // Round robin with all requesters continuously valid.
    do_reset();
    grant_idx_q.delete(); grant_cyc_q.delete();
    for (int i = 0; i < NUM_REQ; i++) set_req(i, 32'h3FC0_0000 + 32'(i), 32'h4000_0000);
    bus.resp_ready = 1'b1;
    repeat (5 * (MUL_LAT + 2)) tick();
    check("rr_grant_count", 64'(grant_idx_q.size()), 64'(5));
    for (int k = 0; k < 5 && k < grant_idx_q.size(); k++) begin
      check("rr_order", 64'(grant_idx_q[k]), 64'(k % NUM_REQ));
      if (k > 0) check("rr_spacing", 64'(grant_cyc_q[k] - grant_cyc_q[k-1]), 64'(MUL_LAT + 2));
    end

    // Reset one cycle into WAIT for requester 3.
    do_reset();
    bus.resp_ready = 1'b0;
    set_req(3, 32'h4000_0000, 32'h4000_0000);
    tick();
    bus.req_valid = '0;
    tick();
    do_reset();
    set_req(0, 32'h3F80_0000, 32'h4000_0000);
    set_req(3, 32'h4000_0000, 32'h4000_0000);
    #1;
    check("rst_restart_grant0", 64'(bus.req_ready), 64'h1);
    tick();
    bus.req_valid = '0;
    bus.resp_ready = 1'b1;
    repeat (MUL_LAT + 2) tick();

    // Zero-operand handling (bypass or normal path).
    do_reset();
    bus.resp_ready = 1'b0;
    set_req(0, 32'h8000_0000, 32'h4000_0000);
    tick();
    bus.req_valid = '0;
    #1;
`ifdef FPM_ZERO_BYPASS_EN
    check("byp_valid_e0", 64'(bus.resp_valid), 64'(1));
    check("byp_resp_m", 64'(bus.resp_m), 64'h8000_0000);
    check("byp_flags", 64'({bus.resp_underflow, bus.resp_overflow}), 64'(0));
`else
    check("nobyp_valid_e0", 64'(bus.resp_valid), 64'(0));
    repeat (MUL_LAT) tick();
    #1;
    check("nobyp_valid", 64'(bus.resp_valid), 64'(1));
    check("nobyp_resp_m", 64'(bus.resp_m), 64'(fpm_ref(32'h8000_0000, 32'h4000_0000) & 34'hFFFF_FFFF));
`endif
    bus.resp_ready = 1'b1;
    tick();

    // Randomized traffic: requesters hold until accepted, occasionally drop.
    do_reset();
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (m_last_win == i) begin
          bus.req_valid[i] = 1'b0;
        end else if (!bus.req_valid[i] && $urandom_range(0, 3) == 0) begin
          set_req(i, rnd_fp(), rnd_fp());
        end else if (bus.req_valid[i] && $urandom_range(0, 31) == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.resp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
